// File: rtl/halftone_image_reconstructor.sv
// Halftone image reconstructor: rebuilds a grayscale raster from a captured
// halftone bit image using a 3x3 [1 2 1; 2 4 2; 1 2 1] edge-replicated kernel,
// streamed out one pixel per accepted valid/ready handshake.
module halftone_image_reconstructor #(
    parameter int unsigned pixel_size = 8,
    parameter int unsigned N_col      = 8,
    parameter int unsigned M_row      = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_n,
    input  logic [1:N_col*M_row]    HTPV_bits,
    input  logic                    Go,
    output logic                    Done,
    output logic [pixel_size-1:0]   pix_data,
    output logic [5:0]              pix_col,
    output logic [5:0]              pix_row,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic                    pix_last
);

    localparam int unsigned NPIX = N_col * M_row;
    localparam int unsigned CW   = 6;
    localparam int unsigned SW   = 5;
    localparam int unsigned MW   = pixel_size + 5;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:NPIX]         r_img;
    logic [CW-1:0]         r_col;
    logic [CW-1:0]         r_row;
    logic                  r_done;
    logic                  r_valid;
    logic                  r_last;
    logic [pixel_size-1:0] r_data;
    logic [CW-1:0]         r_pcol;
    logic [CW-1:0]         r_prow;

    logic                  w_hs;
    logic                  w_load_img;
    logic                  w_upd_pix;
    logic                  w_valid_nxt;
    logic                  w_last_nxt;
    logic [CW-1:0]         w_col_nxt;
    logic [CW-1:0]         w_row_nxt;
    logic [SW-1:0]         w_s;
    logic [MW-1:0]         w_prod;
    logic [pixel_size-1:0] w_pix;

    // Fetch bit (c, r) of the image; bit 1 (top-left) sits in the MSB.
    function automatic logic img_bit(input logic [1:NPIX] img,
                                     input int unsigned c,
                                     input int unsigned r);
        logic [NPIX-1:0] t;
        t = img >> (NPIX - ((r - 1) * N_col + c));
        return t[0];
    endfunction

    assign w_hs = r_valid & pix_ready;

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (Go) w_state_nxt = S_LOAD;
            S_LOAD:   w_state_nxt = S_STREAM;
            S_STREAM: if (w_hs && r_last) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output/datapath next values: counter advance, pixel update, valid/last.
    always_comb begin
        w_load_img  = 1'b0;
        w_upd_pix   = 1'b0;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        case (r_state)
            S_IDLE: begin
                if (Go) begin
                    w_load_img = 1'b1;
                    w_col_nxt  = CW'(1);
                    w_row_nxt  = CW'(1);
                end
            end
            S_LOAD: begin
                w_upd_pix   = 1'b1;
                w_valid_nxt = 1'b1;
                w_last_nxt  = (r_col == CW'(N_col)) && (r_row == CW'(M_row));
            end
            S_STREAM: begin
                if (w_hs) begin
                    if (r_last) begin
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                    end else begin
                        if (r_col == CW'(N_col)) begin
                            w_col_nxt = CW'(1);
                            w_row_nxt = r_row + CW'(1);
                        end else begin
                            w_col_nxt = r_col + CW'(1);
                        end
                        w_upd_pix  = 1'b1;
                        w_last_nxt = (w_col_nxt == CW'(N_col)) && (w_row_nxt == CW'(M_row));
                    end
                end
            end
            default: ;
        endcase
    end

    // 3x3 kernel at the next counter position, clamped to the image edges.
    always_comb begin
        int unsigned cc, cl, cr, rc, rt, rb;
        cc = 32'(w_col_nxt);
        rc = 32'(w_row_nxt);
        cl = (cc > 1)     ? cc - 1 : 1;
        cr = (cc < N_col) ? cc + 1 : N_col;
        rt = (rc > 1)     ? rc - 1 : 1;
        rb = (rc < M_row) ? rc + 1 : M_row;
        w_s = SW'(img_bit(r_img, cl, rt)) + SW'(img_bit(r_img, cr, rt))
            + SW'(img_bit(r_img, cl, rb)) + SW'(img_bit(r_img, cr, rb))
            + ((SW'(img_bit(r_img, cc, rt)) + SW'(img_bit(r_img, cc, rb))
              + SW'(img_bit(r_img, cl, rc)) + SW'(img_bit(r_img, cr, rc))) << 1)
            + (SW'(img_bit(r_img, cc, rc)) << 2);
        w_prod = MW'(w_s) * MW'((2 ** pixel_size) - 1);
        w_pix  = w_prod[pixel_size+3:4];
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_img   <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_done  <= 1'b1;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_pcol  <= '0;
            r_prow  <= '0;
        end else begin
            if (w_load_img) r_img <= HTPV_bits;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_done  <= (w_state_nxt == S_IDLE);
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            if (w_upd_pix) begin
                r_data <= w_pix;
                r_pcol <= w_col_nxt;
                r_prow <= w_row_nxt;
            end
        end
    end

    assign Done      = r_done;
    assign pix_data  = r_data;
    assign pix_col   = r_pcol;
    assign pix_row   = r_prow;
    assign pix_valid = r_valid;
    assign pix_last  = r_last;

endmodule

// File: tb/tb_halftone_image_reconstructor.sv
// Bench for halftone_image_reconstructor: frames of fixed and random images
// compared against a direct 3x3 weighted-average model of the captured image.
module tb_halftone_image_reconstructor;

    localparam int unsigned PS = 8;
    localparam int unsigned NC = 8;
    localparam int unsigned MR = 6;
    localparam int unsigned NM = NC * MR;

    logic          clk_i = 1'b0;
    logic          rst_n;
    logic [1:NM]   htpv;
    logic          go;
    logic          done;
    logic [PS-1:0] pix_data;
    logic [5:0]    pix_col;
    logic [5:0]    pix_row;
    logic          pix_valid;
    logic          pix_ready;
    logic          pix_last;

    int n_tests = 0;
    int n_fail  = 0;
    bit img [NM];

    always #5 clk_i = ~clk_i;

    halftone_image_reconstructor #(.pixel_size(PS), .N_col(NC), .M_row(MR)) dut (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .HTPV_bits (htpv),
        .Go        (go),
        .Done      (done),
        .pix_data  (pix_data),
        .pix_col   (pix_col),
        .pix_row   (pix_row),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_last  (pix_last)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Pack the model image so that img[0] (col 1, row 1) lands on bit 1.
    function automatic logic [1:NM] pack_img();
        logic [1:NM] b;
        b = '0;
        for (int k = 0; k < NM; k++) b = (b << 1) | NM'(img[k]);
        return b;
    endfunction

    function automatic int clampi(input int v, input int hi);
        if (v < 1)  return 1;
        if (v > hi) return hi;
        return v;
    endfunction

    // Weighted 3x3 average with edge replication, scaled to full PS range.
    function automatic int model_pix(input int c, input int r);
        int s, cc, rr, w;
        s = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                cc = clampi(c + dx, NC);
                rr = clampi(r + dy, MR);
                w  = (2 - (dx < 0 ? -dx : dx)) * (2 - (dy < 0 ? -dy : dy));
                if (img[(rr - 1) * NC + cc - 1]) s += w;
            end
        end
        return (s * ((1 << PS) - 1)) / 16;
    endfunction

    // mode 0: ready always high; 1: random ready; 2: 3-cycle stall on (5,1),
    // stray Go pulses and a changing HTPV_bits input. abort >= 0 resets after
    // that many handshakes.
    task automatic run_frame(input int mode, input int abort);
        int idx, cyc, stall, ec, er;
        bit rdy;
        idx = 0; cyc = 0; stall = 0;
        htpv = pack_img();
        @(negedge clk_i);
        check("idle_done", done, 1);
        go = 1'b1;
        @(negedge clk_i);
        go = 1'b0;
        check("load_done", done, 0);
        check("load_valid", pix_valid, 0);
        if (mode == 2) htpv = NM'({$urandom, $urandom});
        while (idx < NM && cyc < 1000) begin
            @(negedge clk_i);
            cyc++;
            ec = idx % NC + 1;
            er = idx / NC + 1;
            check("valid", pix_valid, 1);
            check("col", pix_col, ec);
            check("row", pix_row, er);
            check("data", pix_data, model_pix(ec, er));
            check("last", pix_last, (idx == NM - 1) ? 1 : 0);
            check("busy_done", done, 0);
            if (abort >= 0 && idx == abort) break;
            case (mode)
                1:       rdy = 1'($urandom_range(0, 1));
                2:       begin
                             if (idx == 4 && stall < 3) begin rdy = 1'b0; stall++; end
                             else rdy = 1'b1;
                             go = (idx == NM - 1) ? 1'b1 : 1'($urandom_range(0, 1));
                         end
                default: rdy = 1'b1;
            endcase
            pix_ready = rdy;
            if (rdy) idx++;
        end
        if (abort >= 0) begin
            rst_n = 1'b0;
            @(negedge clk_i);
            check("rst_valid", pix_valid, 0);
            check("rst_done", done, 1);
            check("rst_data", pix_data, 0);
            check("rst_col", pix_col, 0);
            check("rst_row", pix_row, 0);
            check("rst_last", pix_last, 0);
            rst_n = 1'b1;
            pix_ready = 1'b0;
            return;
        end
        check("frame_complete", idx, NM);
        @(negedge clk_i);
        go = 1'b0;
        pix_ready = 1'b0;
        check("end_done", done, 1);
        check("end_valid", pix_valid, 0);
        check("end_last", pix_last, 0);
        if (mode == 0) check("frame_cycles", cyc, NM);
        if (mode == 2) begin
            check("stall_cycles", stall, 3);
            @(negedge clk_i);
            check("go_on_last_ignored", done, 1);
            check("go_on_last_valid", pix_valid, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; go = 1'b0; pix_ready = 1'b0; htpv = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("reset_done", done, 1);
        check("reset_valid", pix_valid, 0);
        check("reset_last", pix_last, 0);
        check("reset_data", pix_data, 0);
        check("reset_col", pix_col, 0);
        check("reset_row", pix_row, 0);
        rst_n = 1'b1;

        foreach (img[k]) img[k] = 1'b0;
        run_frame(0, -1);
        foreach (img[k]) img[k] = 1'b1;
        run_frame(0, -1);
        foreach (img[k]) img[k] = 1'b0;
        img[0] = 1'b1;
        check("single_11", model_pix(1, 1), 143);
        run_frame(0, -1);
        foreach (img[k]) img[k] = 1'((k % NC + 1 + k / NC + 1) % 2 == 0);
        run_frame(0, -1);
        foreach (img[k]) img[k] = 1'($urandom_range(0, 1));
        run_frame(1, -1);
        foreach (img[k]) img[k] = 1'($urandom_range(0, 1));
        run_frame(2, -1);
        foreach (img[k]) img[k] = 1'($urandom_range(0, 1));
        run_frame(0, 10);
        foreach (img[k]) img[k] = 1'($urandom_range(0, 1));
        run_frame(0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
